// File: rtl/binary_to_bcd_conv.sv
// rtl/binary_to_bcd_conv.sv - 7-bit binary to two-digit BCD converter with combinational and registered results
//
// Ports:
//   i_clk        in   1  clock; registered outputs update on rising edge
//   i_reset      in   1  asynchronous active-high reset of registered outputs
//   i_ena        in   1  capture enable for registered outputs
//   i_binary     in   7  unsigned value to convert (0..99 valid, 100..127 saturate)
//   o_bcd_msb    out  4  combinational tens digit
//   o_bcd_lsb    out  4  combinational units digit
//   o_overflow   out  1  combinational, set when i_binary >= 100
//   o_bcd_msb_r  out  4  registered tens digit
//   o_bcd_lsb_r  out  4  registered units digit
//   o_overflow_r out  1  registered overflow flag

module binary_to_bcd_conv (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic [6:0] i_binary,
  output logic [3:0] o_bcd_msb,
  output logic [3:0] o_bcd_lsb,
  output logic       o_overflow,
  output logic [3:0] o_bcd_msb_r,
  output logic [3:0] o_bcd_lsb_r,
  output logic       o_overflow_r
);

  // Double-dabble working register: [18:15] hundreds, [14:11] tens,
  // [10:7] units, [6:0] binary bits still to be shifted in.
  logic [18:0] dabble_sr;
  logic [3:0]  hund_dig;
  logic [3:0]  tens_dig;
  logic [3:0]  unit_dig;

  always_comb begin
    dabble_sr = {12'd0, i_binary};
    for (int i = 0; i < 7; i++) begin
      // Correct any digit that would exceed 9 after doubling.
      if (dabble_sr[10:7] >= 4'd5)
        dabble_sr[10:7] = dabble_sr[10:7] + 4'd3;
      if (dabble_sr[14:11] >= 4'd5)
        dabble_sr[14:11] = dabble_sr[14:11] + 4'd3;
      if (dabble_sr[18:15] >= 4'd5)
        dabble_sr[18:15] = dabble_sr[18:15] + 4'd3;
      dabble_sr = dabble_sr << 1;
    end
    hund_dig = dabble_sr[18:15];
    tens_dig = dabble_sr[14:11];
    unit_dig = dabble_sr[10:7];
  end

  // Any hundreds digit means the value cannot be shown on two digits:
  // clamp the display to 99 and flag it.
  logic       ovf_c;
  logic [3:0] msb_c;
  logic [3:0] lsb_c;

  always_comb begin
    ovf_c = (hund_dig != 4'd0);
    msb_c = ovf_c ? 4'd9 : tens_dig;
    lsb_c = ovf_c ? 4'd9 : unit_dig;
  end

  assign o_bcd_msb  = msb_c;
  assign o_bcd_lsb  = lsb_c;
  assign o_overflow = ovf_c;

  // Registered copy for downstream logic that needs a clean launch point.
  logic [3:0] msb_q, msb_d;
  logic [3:0] lsb_q, lsb_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    msb_d = msb_q;
    lsb_d = lsb_q;
    ovf_d = ovf_q;
    if (i_ena) begin
      msb_d = msb_c;
      lsb_d = lsb_c;
      ovf_d = ovf_c;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      msb_q <= 4'd0;
      lsb_q <= 4'd0;
      ovf_q <= 1'b0;
    end else begin
      msb_q <= msb_d;
      lsb_q <= lsb_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_bcd_msb_r  = msb_q;
  assign o_bcd_lsb_r  = lsb_q;
  assign o_overflow_r = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_conv.sv
// tb/tb_binary_to_bcd_conv.sv - scoreboard bench for binary_to_bcd_conv

module tb_binary_to_bcd_conv;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [6:0] bin;
  logic [3:0] msb, lsb, msb_r, lsb_r;
  logic       ovf, ovf_r;

  binary_to_bcd_conv dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ena       (ena),
    .i_binary    (bin),
    .o_bcd_msb   (msb),
    .o_bcd_lsb   (lsb),
    .o_overflow  (ovf),
    .o_bcd_msb_r (msb_r),
    .o_bcd_lsb_r (lsb_r),
    .o_overflow_r(ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] val;
    logic [3:0] m;
    logic [3:0] l;
    logic       o;
    logic [3:0] mr;
    logic [3:0] lr;
    logic       orr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: decimal arithmetic, saturating at 99.
  function automatic void ref_conv(input int v, output int m, output int l, output int o);
    if (v >= 100) begin
      m = 9; l = 9; o = 1;
    end else begin
      m = v / 10; l = v % 10; o = 0;
    end
  endfunction

  // Model of what the registers hold, plus the inputs seen at the last edge.
  int   reg_m = 0, reg_l = 0, reg_o = 0;
  int   cur_bin = 0;
  logic cur_ena = 1'b0;
  logic cur_rst = 1'b1;

  task automatic step(input int b, input logic e, input logic r);
    int m, l, o;
    exp_t x;
    @(posedge clk);
    #2;
    if (cur_rst) begin
      reg_m = 0; reg_l = 0; reg_o = 0;
    end else if (cur_ena) begin
      ref_conv(cur_bin, reg_m, reg_l, reg_o);
    end
    bin = 7'(b);
    ena = e;
    rst = r;
    cur_bin = b; cur_ena = e; cur_rst = r;
    if (r) begin
      reg_m = 0; reg_l = 0; reg_o = 0;
    end
    ref_conv(b, m, l, o);
    x.val = 7'(b);
    x.m = 4'(m); x.l = 4'(l); x.o = o[0];
    x.mr = 4'(reg_m); x.lr = 4'(reg_l); x.orr = reg_o[0];
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int v, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s (input %0d): got %0d expected %0d", name, v, act, req);
    end
  endtask

  // Monitor: compares mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("msb",   x.val, msb,   x.m);
      chk("lsb",   x.val, lsb,   x.l);
      chk("ovf",   x.val, ovf,   x.o);
      chk("msb_r", x.val, msb_r, x.mr);
      chk("lsb_r", x.val, lsb_r, x.lr);
      chk("ovf_r", x.val, ovf_r, x.orr);
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    ena = 1'b0;
    bin = 7'd0;

    // Reset held, enable active: registers stay zero.
    step(0, 1'b1, 1'b1);
    step(77, 1'b1, 1'b1);

    // Full sweep including saturating range.
    for (int v = 0; v < 128; v++) step(v, 1'b1, 1'b0);

    // One-cycle latency.
    step(42, 1'b1, 1'b0);
    step(42, 1'b0, 1'b0);

    // Enable hold.
    step(23, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(57, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle, held, then released.
    step(88, 1'b1, 1'b0);
    step(88, 1'b0, 1'b0);
    step(88, 1'b1, 1'b1);
    step(88, 1'b1, 1'b1);
    step(61, 1'b1, 1'b0);
    step(61, 1'b0, 1'b0);

    // Registered overflow.
    step(115, 1'b1, 1'b0);
    step(115, 1'b0, 1'b0);

    // Random traffic.
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 127), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_conv.md
Name:
binary_to_bcd_conv

Overview:
- Converts a 7-bit unsigned binary value (0..99 valid range) into two packed BCD digits: tens and units.
- Feeds the clock display digit drivers (hours/minutes/seconds fields).
- Provides a zero-latency combinational result and a registered copy of the same result for timing-clean downstream use.

Parameters:
- none (widths fixed: 7-bit input, two 4-bit BCD digits)

Ports:
- i_clk  input  1  system clock; registered outputs update on rising edge
- i_reset  input  1  asynchronous, active-high reset; clears registered outputs
- i_ena  input  1  capture enable for registered outputs
- i_binary  input  7  unsigned binary value to convert
- o_bcd_msb  output  4  combinational tens digit
- o_bcd_lsb  output  4  combinational units digit
- o_overflow  output  1  combinational; 1 when i_binary >= 100
- o_bcd_msb_r  output  4  registered tens digit
- o_bcd_lsb_r  output  4  registered units digit
- o_overflow_r  output  1  registered overflow flag

Behaviour:
- Combinational path: o_bcd_msb, o_bcd_lsb and o_overflow depend only on i_binary. Zero latency. They settle within the same cycle and have no clock or reset dependency.
- For i_binary in 0..99:
  - o_bcd_msb = i_binary / 10
  - o_bcd_lsb = i_binary % 10
  - o_overflow = 0
- For i_binary in 100..127:
  - o_overflow = 1
  - o_bcd_msb = 9, o_bcd_lsb = 9 (saturate to 99)
- Each digit output always lies in 0..9. Codes 10..15 are never driven.
- Conversion method: shift-and-add-3 (double dabble) over the 7 input bits, producing hundreds/tens/units. Before each shift, any digit >= 5 gets 3 added. A non-zero hundreds digit selects saturation. A divider/LUT is equally acceptable if the outputs are identical.
- Registered path: on rising i_clk with i_ena = 1, o_bcd_msb_r/o_bcd_lsb_r/o_overflow_r capture the current combinational values. One-cycle latency.
- With i_ena = 0 the registered outputs hold their values.
- Reset: i_reset = 1 immediately (asynchronously) forces o_bcd_msb_r = 0, o_bcd_lsb_r = 0, o_overflow_r = 0, regardless of the clock.
- Reset overrides i_ena. The registered outputs stay at 0 while i_reset is held.
- First capture occurs on the first rising edge after i_reset deasserts with i_ena = 1.
- Reset does not affect the combinational outputs.
- Input changes mid-cycle affect only the combinational outputs until the next enabled edge.
- Undefined input bits must not occur. No X-propagation handling is required.

Test Plan:
- Exhaustive sweep of i_binary 0..99, checking combinational outputs each step:
  - o_bcd_msb = v/10, o_bcd_lsb = v%10, o_overflow = 0
  - e.g. 0 -> 0,0; 9 -> 0,9; 10 -> 1,0; 59 -> 5,9; 99 -> 9,9
- Sweep 100..127:
  - 100 -> 9,9, o_overflow = 1
  - 127 -> 9,9, o_overflow = 1
  - no digit ever exceeds 9
- Registered latency:
  - i_ena = 1, i_binary = 42 -> after one rising edge, o_bcd_msb_r = 4, o_bcd_lsb_r = 2
  - before that edge, the registered outputs still show the previous value
- Enable hold:
  - capture 23, set i_ena = 0, drive 57 for 3 cycles -> registered outputs remain 2,3
  - combinational outputs show 5,7 immediately
- Asynchronous reset:
  - with registered outputs at 8,8, assert i_reset between clock edges -> registered outputs go 0,0,0 without waiting for an edge
  - hold reset with i_ena = 1 -> outputs stay 0
  - release reset, next edge with i_binary = 61 -> 6,1
- Overflow registered: capture i_binary = 115 -> o_overflow_r = 1, digits 9,9.
